vx_scope_trig: RTL and testbench
================================

Name: vx_scope_trig

Overview:
- Multi-channel debug capture scope with a programmable data-match trigger and a pre-/post-trigger circular buffer.
- Samples CHANNELS probe buses into one delta-compressed ring. On trigger it keeps the history before the trigger plus a programmable number of entries after it.
- Sits beside the core behind the same serial scope command bus used by the host scope driver.

Parameters:
CHANNELS, 4, number of probe channels
DATAW, 32, bits per channel; SAMPW = CHANNELS*DATAW
BUSW, 64, host bus width; commands use bus_in[3:0] as cmd_type and bus_in[BUSW-1:4] as cmd_data
SIZE, 256, ring depth in entries; power of two, >= 4
DELTAW, 16, inter-sample idle-cycle counter width; MAX_DELTA = 2^DELTAW-1
TRIGW, 32, width of the trigger compare on sample[TRIGW-1:0]; TRIGW <= min(SAMPW, BUSW-4)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
stop  input  1  force end of capture
ext_trig  input  1  external trigger, OR'd with the match trigger
changed  input  CHANNELS  per-channel sample-worthy event
data_in  input  SAMPW  concatenated probes; channel i at [i*DATAW +: DATAW]
bus_in  input  BUSW  command word
bus_write  input  1  command strobe
bus_read  input  1  read-advance strobe
bus_out  output  BUSW  combinational read data
armed  output  1  registered; high in ARMED or POST
done  output  1  registered; high in DONE

Behaviour:
- reset low asynchronously clears all state:
  - state=IDLE, pointers, counters, mask, value, post_len, timestamp and trig_time all 0; trig_en=0.
  - armed=0, done=0; bus_out reflects get_cmd=STATUS, i.e. 0.
- timestamp: 64-bit free-running counter, +1 per cycle.
- Commands, applied when bus_write=1:
  - 0 STATUS, 1 DATA, 2 WIDTH, 3 COUNT, 8 TSTAMP: set get_cmd.
  - 4 SET_POST: post_len <= cmd_data[$clog2(SIZE):0].
  - 5 SET_MASK: mask <= cmd_data[TRIGW-1:0]; trig_en <= (mask != 0).
  - 6 SET_VAL: val <= cmd_data[TRIGW-1:0].
  - 7 ARM: waddr=0, count=0, delta=0, flush=1, wrapped=0, triggered=0, rd state cleared; state -> ARMED. Accepted from any state; discards prior data.
  - 9 ABORT: state -> IDLE, done=0.
  - Other codes: ignored.
- Record condition, in ARMED or POST: rec = flush | (|changed) | force. force=1 on the trigger cycle.
  - On rec: ring[waddr] <= {delta, data_in}; waddr+1 with mod-SIZE wrap; count = min(count+1, SIZE); wrapped set when count saturates; delta <= 0; flush <= 0.
  - Otherwise: delta+1; flush <= (delta == MAX_DELTA-1), so delta never exceeds MAX_DELTA.
- FSM:
  - IDLE: no recording.
  - ARMED: trigger = ext_trig | (trig_en & ((data_in[TRIGW-1:0] & mask) == (val & mask))). On trigger: trig_time <= timestamp, triggered=1, sample forced. Then -> DONE if post_len==0, else -> POST with post_cnt=post_len.
  - POST: each rec decrements post_cnt; the rec that brings it to 0 -> DONE.
  - stop=1 in ARMED/POST -> DONE the next cycle. The sample on the stop cycle is recorded if rec. stop has priority over trigger.
  - DONE: frozen until ARM, ABORT, or readout complete.
  - ABORT or ARM on the same cycle as a trigger or stop wins.
- Readout (DONE, get_cmd=DATA, bus_read=1):
  - Start pointer: raddr = wrapped ? waddr : 0.
  - Each entry reads 1 delta word, then WORDS = ceil(SAMPW/BUSW) data words, least significant first, zero-extended.
  - Each bus_read advances one word. After the final word of the count-th entry: state -> IDLE, done=0.
  - bus_read with any other get_cmd has no side effect.
- bus_out, combinational by get_cmd:
  - STATUS = {wrapped, triggered, armed, done} in bits [3:0].
  - WIDTH = SAMPW.
  - COUNT = count.
  - TSTAMP = trig_time truncated to BUSW.
  - DATA = current word.
  - Anything else = 0.
- Latency: data_in is captured in the cycle it is presented; command effects are visible the cycle after bus_write.

Test Plan:
- ARM with mask=0, post_len=3; ext_trig at cycle 10; changed each cycle from arm -> count=14 (10 pre + trigger + 3 post); done=1; STATUS=0b0101; 14×(1+2) DATA words with SAMPW=128, BUSW=64; done=0 afterwards.
- mask=0xFF, val=0x5A, post_len=0; ramp data_in[7:0] 0..255, one change per cycle -> triggers on 0x5A; last entry data=0x5A; TSTAMP = timestamp at that cycle.
- No changed for 70000 cycles after ARM with DELTAW=16 -> entries at cycles 0 and 65536 with deltas 0 and 65535; never exceeds MAX_DELTA.
- SIZE=256, trigger after 300 records, post_len=10 -> wrapped=1; count=256; first read entry is the 55th record (index 54).
- stop and ext_trig asserted together in ARMED -> DONE, triggered=0. ARM during POST -> restarts with count=0. Reset pulse low mid-POST -> all outputs 0 immediately.

Source files
------------

// File: rtl/vx_scope_trig_if.sv
// Host scope command bus: command word and write/read strobes toward the
// scope, combinational read data back to the host.
interface vx_scope_trig_if #(
  parameter int BUSW = 64
) ();
  logic [BUSW-1:0] bus_in;
  logic            bus_write;
  logic            bus_read;
  logic [BUSW-1:0] bus_out;

  modport master (output bus_in, output bus_write, output bus_read, input bus_out);
  modport slave  (input bus_in, input bus_write, input bus_read, output bus_out);
endinterface

// File: rtl/vx_scope_trig.sv
// Multi-channel debug capture scope. Probe samples are delta-compressed into a
// circular ring; a data-match or external trigger freezes the ring after a
// programmable number of post-trigger entries, and the host drains it word by
// word over the scope command bus.
module vx_scope_trig #(
  parameter int CHANNELS = 4,
  parameter int DATAW    = 32,
  parameter int BUSW     = 64,
  parameter int SIZE     = 256,
  parameter int DELTAW   = 16,
  parameter int TRIGW    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stop_i,
  input  logic                      ext_trig_i,
  input  logic [CHANNELS-1:0]       changed_i,
  input  logic [CHANNELS*DATAW-1:0] data_in_i,
  vx_scope_trig_if.slave            bus,
  output logic                      armed_o,
  output logic                      done_o
);
  localparam int SAMPW = CHANNELS * DATAW;
  localparam int ADDRW = $clog2(SIZE);
  localparam int CNTW  = ADDRW + 1;
  localparam int ENTW  = DELTAW + SAMPW;
  localparam int WORDS = (SAMPW + BUSW - 1) / BUSW;
  localparam int WSELW = $clog2(WORDS + 1);

  localparam logic [DELTAW-1:0] MAX_DELTA = '1;
  localparam logic [CNTW-1:0]   FULL      = CNTW'(SIZE);
  localparam logic [WSELW-1:0]  LAST_WORD = WSELW'(WORDS);

  localparam logic [3:0] CMD_STATUS   = 4'd0;
  localparam logic [3:0] CMD_DATA     = 4'd1;
  localparam logic [3:0] CMD_WIDTH    = 4'd2;
  localparam logic [3:0] CMD_COUNT    = 4'd3;
  localparam logic [3:0] CMD_SET_POST = 4'd4;
  localparam logic [3:0] CMD_SET_MASK = 4'd5;
  localparam logic [3:0] CMD_SET_VAL  = 4'd6;
  localparam logic [3:0] CMD_ARM      = 4'd7;
  localparam logic [3:0] CMD_TSTAMP   = 4'd8;
  localparam logic [3:0] CMD_ABORT    = 4'd9;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [3:0]        get_cmd_q, get_cmd_d;
  logic [CNTW-1:0]   post_len_q, post_len_d;
  logic [TRIGW-1:0]  mask_q, mask_d;
  logic [TRIGW-1:0]  val_q, val_d;
  logic              trig_en_q, trig_en_d;
  logic [63:0]       timestamp_q, timestamp_d;
  logic [63:0]       trig_time_q, trig_time_d;
  logic [ADDRW-1:0]  waddr_q, waddr_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic [DELTAW-1:0] delta_q, delta_d;
  logic              flush_q, flush_d;
  logic              wrapped_q, wrapped_d;
  logic              triggered_q, triggered_d;
  logic [CNTW-1:0]   post_cnt_q, post_cnt_d;
  logic [CNTW-1:0]   rd_idx_q, rd_idx_d;
  logic [WSELW-1:0]  rd_word_q, rd_word_d;
  logic              armed_q, done_q;

  logic [ENTW-1:0]   ring [SIZE];

  logic [3:0]        cmd_type;
  logic              cmd_arm, cmd_abort;
  logic              capturing, trig_hit, trig_fire, rec, rd_fire;

  logic [ADDRW-1:0]        rd_addr;
  logic [ENTW-1:0]         rd_entry;
  logic [WORDS*BUSW-1:0]   samp_pad;
  logic [BUSW-1:0]         rd_word;

  // Decode the command strobe, trigger condition and record/read enables.
  always_comb begin
    cmd_type  = bus.bus_in[3:0];
    cmd_arm   = bus.bus_write && (cmd_type == CMD_ARM);
    cmd_abort = bus.bus_write && (cmd_type == CMD_ABORT);
    capturing = (state_q == S_ARMED) || (state_q == S_POST);
    trig_hit  = ext_trig_i ||
                (trig_en_q && ((data_in_i[TRIGW-1:0] & mask_q) == (val_q & mask_q)));
    // stop, ARM and ABORT all outrank a trigger on the same cycle.
    trig_fire = (state_q == S_ARMED) && trig_hit && !stop_i && !cmd_arm && !cmd_abort;
    rec       = capturing && !cmd_arm && !cmd_abort &&
                (flush_q || (|changed_i) || trig_fire);
    rd_fire   = (state_q == S_DONE) && bus.bus_read && (get_cmd_q == CMD_DATA) &&
                !cmd_arm && !cmd_abort;
  end

  // Next-state logic: configuration, ring bookkeeping, FSM and read pointer.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    state_d     = state_q;
    get_cmd_d   = get_cmd_q;
    post_len_d  = post_len_q;
    mask_d      = mask_q;
    val_d       = val_q;
    trig_en_d   = trig_en_q;
    timestamp_d = timestamp_q + 64'd1;
    trig_time_d = trig_time_q;
    waddr_d     = waddr_q;
    count_d     = count_q;
    delta_d     = delta_q;
    flush_d     = flush_q;
    wrapped_d   = wrapped_q;
    triggered_d = triggered_q;
    post_cnt_d  = post_cnt_q;
    rd_idx_d    = rd_idx_q;
    rd_word_d   = rd_word_q;

    if (bus.bus_write) begin
      case (cmd_type)
        CMD_STATUS, CMD_DATA, CMD_WIDTH, CMD_COUNT, CMD_TSTAMP: get_cmd_d = cmd_type;
        CMD_SET_POST: post_len_d = bus.bus_in[4 +: CNTW];
        CMD_SET_MASK: begin
          mask_d    = bus.bus_in[4 +: TRIGW];
          trig_en_d = |bus.bus_in[4 +: TRIGW];
        end
        CMD_SET_VAL:  val_d = bus.bus_in[4 +: TRIGW];
        default: ;
      endcase
    end

    // Ring bookkeeping: a record stores the idle gap since the previous one;
    // a forced flush caps the gap at MAX_DELTA.
    if (rec) begin
      waddr_d = waddr_q + ADDRW'(1);
      if (count_q != FULL) count_d = count_q + CNTW'(1);
      if (count_q >= FULL - CNTW'(1)) wrapped_d = 1'b1;
      delta_d = '0;
      flush_d = 1'b0;
    end else if (capturing) begin
      delta_d = delta_q + DELTAW'(1);
      flush_d = (delta_q == MAX_DELTA - DELTAW'(1));
    end

    case (state_q)
      S_ARMED: begin
        if (stop_i) begin
          state_d = S_DONE;
        end else if (trig_fire) begin
          trig_time_d = timestamp_q;
          triggered_d = 1'b1;
          post_cnt_d  = post_len_q;
          state_d     = (post_len_q == '0) ? S_DONE : S_POST;
        end
      end
      S_POST: begin
        if (stop_i) begin
          state_d = S_DONE;
        end else if (rec) begin
          post_cnt_d = post_cnt_q - CNTW'(1);
          if (post_cnt_q <= CNTW'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (rd_fire) begin
          if (rd_word_q == LAST_WORD) begin
            rd_word_d = '0;
            rd_idx_d  = rd_idx_q + CNTW'(1);
            if (rd_idx_q + CNTW'(1) >= count_q) state_d = S_IDLE;
          end else begin
            rd_word_d = rd_word_q + WSELW'(1);
          end
        end
      end
      default: ;
    endcase

    if (cmd_abort) state_d = S_IDLE;
    if (cmd_arm) begin
      state_d     = S_ARMED;
      waddr_d     = '0;
      count_d     = '0;
      delta_d     = '0;
      flush_d     = 1'b1;
      wrapped_d   = 1'b0;
      triggered_d = 1'b0;
      post_cnt_d  = '0;
      rd_idx_d    = '0;
      rd_word_d   = '0;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      get_cmd_q   <= CMD_STATUS;
      post_len_q  <= '0;
      mask_q      <= '0;
      val_q       <= '0;
      trig_en_q   <= 1'b0;
      timestamp_q <= '0;
      trig_time_q <= '0;
      waddr_q     <= '0;
      count_q     <= '0;
      delta_q     <= '0;
      flush_q     <= 1'b0;
      wrapped_q   <= 1'b0;
      triggered_q <= 1'b0;
      post_cnt_q  <= '0;
      rd_idx_q    <= '0;
      rd_word_q   <= '0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      get_cmd_q   <= get_cmd_d;
      post_len_q  <= post_len_d;
      mask_q      <= mask_d;
      val_q       <= val_d;
      trig_en_q   <= trig_en_d;
      timestamp_q <= timestamp_d;
      trig_time_q <= trig_time_d;
      waddr_q     <= waddr_d;
      count_q     <= count_d;
      delta_q     <= delta_d;
      flush_q     <= flush_d;
      wrapped_q   <= wrapped_d;
      triggered_q <= triggered_d;
      post_cnt_q  <= post_cnt_d;
      rd_idx_q    <= rd_idx_d;
      rd_word_q   <= rd_word_d;
      armed_q     <= (state_d == S_ARMED) || (state_d == S_POST);
      done_q      <= (state_d == S_DONE);
    end
  end

  // Ring write: one {delta, sample} entry per recorded cycle.
  // NOTE: the ring has no reset; entries are only read back after being
  // written, as bounded by count and wrapped.
  always_ff @(posedge clk) begin
    if (rec) ring[waddr_q] <= {delta_q, data_in_i};
  end

  // Read mux: oldest-first ring entry split into delta word then data words.
  always_comb begin
    rd_addr  = (wrapped_q ? waddr_q : '0) + rd_idx_q[ADDRW-1:0];
    rd_entry = ring[rd_addr];
    samp_pad = '0;
    samp_pad[SAMPW-1:0] = rd_entry[SAMPW-1:0];
    rd_word  = BUSW'(rd_entry[ENTW-1 -: DELTAW]);
    for (int w = 0; w < WORDS; w++) begin
      if (rd_word_q == WSELW'(w + 1)) rd_word = samp_pad[w*BUSW +: BUSW];
    end
    case (get_cmd_q)
      CMD_STATUS: bus.bus_out = BUSW'({wrapped_q, triggered_q, armed_q, done_q});
      CMD_DATA:   bus.bus_out = rd_word;
      CMD_WIDTH:  bus.bus_out = BUSW'(SAMPW);
      CMD_COUNT:  bus.bus_out = BUSW'(count_q);
      CMD_TSTAMP: bus.bus_out = BUSW'(trig_time_q);
      default:    bus.bus_out = '0;
    endcase
  end

  assign armed_o = armed_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_vx_scope_trig.sv
// Directed testbench for vx_scope_trig: table-driven register readback plus
// hand-written capture/trigger/readout sequences.
module tb_vx_scope_trig;
  localparam int CHANNELS = 4;
  localparam int DATAW    = 32;
  localparam int BUSW     = 64;
  localparam int SIZE     = 256;
  localparam int DELTAW   = 16;
  localparam int TRIGW    = 32;
  localparam int SAMPW    = CHANNELS * DATAW;

  localparam logic [3:0] C_STATUS   = 4'd0;
  localparam logic [3:0] C_DATA     = 4'd1;
  localparam logic [3:0] C_WIDTH    = 4'd2;
  localparam logic [3:0] C_COUNT    = 4'd3;
  localparam logic [3:0] C_SET_POST = 4'd4;
  localparam logic [3:0] C_SET_MASK = 4'd5;
  localparam logic [3:0] C_SET_VAL  = 4'd6;
  localparam logic [3:0] C_ARM      = 4'd7;
  localparam logic [3:0] C_TSTAMP   = 4'd8;
  localparam logic [3:0] C_ABORT    = 4'd9;

  typedef struct {
    logic [3:0]  cmd;
    logic [59:0] arg;
    logic [63:0] exp_bus;
    logic        exp_armed;
    logic        exp_done;
  } vec_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                stop;
  logic                ext_trig;
  logic [CHANNELS-1:0] changed;
  logic [SAMPW-1:0]    data_in;
  logic                armed;
  logic                done;

  vx_scope_trig_if #(.BUSW(BUSW)) bus_if ();

  vx_scope_trig #(
    .CHANNELS(CHANNELS), .DATAW(DATAW), .BUSW(BUSW),
    .SIZE(SIZE), .DELTAW(DELTAW), .TRIGW(TRIGW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stop_i     (stop),
    .ext_trig_i (ext_trig),
    .changed_i  (changed),
    .data_in_i  (data_in),
    .bus        (bus_if),
    .armed_o    (armed),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  // Bench copy of the free-running timestamp, for expected trig_time values.
  longint unsigned tb_cyc;
  always @(posedge clk or negedge reset) begin
    if (!reset) tb_cyc <= 0;
    else        tb_cyc <= tb_cyc + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic [SAMPW-1:0]  q_data[$];
  logic [DELTAW-1:0] q_delta[$];
  vec_t              vecs[6];
  longint unsigned   trig_ts;
  int                last_c;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [SAMPW-1:0] mk(input int c);
    return {32'hDEAD_0000 | 32'(c), 32'hBEEF_0000 | 32'(c),
            32'hCAFE_0000 | 32'(c), 32'h1234_5600 | 32'(c)};
  endfunction

  // One capture cycle: present inputs, then move to the next sampling point.
  task automatic drive(input logic [SAMPW-1:0] d, input logic [3:0] ch,
                       input logic et, input logic st);
    data_in = d; changed = ch; ext_trig = et; stop = st;
    @(negedge clk);
  endtask

  // One bus command cycle with the capture inputs quiet.
  task automatic bus_cmd(input logic [3:0] c, input logic [59:0] arg);
    changed = '0; ext_trig = 1'b0; stop = 1'b0;
    bus_if.bus_in    = {arg, c};
    bus_if.bus_write = 1'b1;
    @(negedge clk);
    bus_if.bus_write = 1'b0;
    bus_if.bus_in    = '0;
  endtask

  // Drain n entries (DATA already selected) and compare against the queues.
  task automatic read_entries(input int first, input int n);
    logic [SAMPW-1:0] d;
    for (int e = 0; e < n; e++) begin
      d = q_data[first + e];
      bus_if.bus_read = 1'b1;
      check($sformatf("rd%0d_delta", first + e), bus_if.bus_out, 64'(q_delta[first + e]));
      @(negedge clk);
      check($sformatf("rd%0d_lo", first + e), bus_if.bus_out, d[63:0]);
      @(negedge clk);
      check($sformatf("rd%0d_hi", first + e), bus_if.bus_out, d[127:64]);
      @(negedge clk);
    end
    bus_if.bus_read = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; stop = 1'b0; ext_trig = 1'b0; changed = '0; data_in = '0;
    bus_if.bus_in = '0; bus_if.bus_write = 1'b0; bus_if.bus_read = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_flags", {62'd0, armed, done}, 64'd0);
    check("rst_bus", bus_if.bus_out, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // ---- ARM then ABORT ----
    bus_cmd(C_ARM, 60'd0);
    check("arm_flags", {62'd0, armed, done}, 64'b10);
    bus_cmd(C_ABORT, 60'd0);
    check("abort_flags", {62'd0, armed, done}, 64'b00);

    // ---- Test 1: ext_trig at cycle 10, post_len 3 ----
    bus_cmd(C_SET_MASK, 60'd0);
    bus_cmd(C_SET_POST, 60'd3);
    bus_cmd(C_ARM, 60'd0);
    q_data = {}; q_delta = {};
    for (int c = 0; c < 14; c++) begin
      q_data.push_back(mk(c)); q_delta.push_back('0);
      if (c == 10) trig_ts = tb_cyc;
      drive(mk(c), 4'b0001, c == 10, 1'b0);
    end
    changed = '0;
    check("t1_flags", {62'd0, armed, done}, 64'b01);

    vecs[0] = '{C_STATUS,  60'd0,  64'h5,          1'b0, 1'b1};
    vecs[1] = '{C_WIDTH,   60'd0,  64'd128,        1'b0, 1'b1};
    vecs[2] = '{C_TSTAMP,  60'd0,  64'(trig_ts),   1'b0, 1'b1};
    vecs[3] = '{C_COUNT,   60'd0,  64'd14,         1'b0, 1'b1};
    vecs[4] = '{4'hF,      60'h7,  64'd14,         1'b0, 1'b1};
    vecs[5] = '{C_SET_VAL, 60'h33, 64'd14,         1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      bus_cmd(vecs[i].cmd, vecs[i].arg);
      check($sformatf("vec%0d_bus", i), bus_if.bus_out, vecs[i].exp_bus);
      check($sformatf("vec%0d_flags", i), {62'd0, armed, done},
            {62'd0, vecs[i].exp_armed, vecs[i].exp_done});
    end

    // bus_read with get_cmd=COUNT must not move the read pointer.
    bus_if.bus_read = 1'b1;
    repeat (3) @(negedge clk);
    bus_if.bus_read = 1'b0;
    bus_cmd(C_DATA, 60'd0);
    read_entries(0, 14);
    check("t1_after_rd", {62'd0, armed, done}, 64'b00);

    // ---- Test 2: data-match trigger on 0x5A, post_len 0 ----
    bus_cmd(C_SET_MASK, 60'hFF);
    bus_cmd(C_SET_VAL, 60'h5A);
    bus_cmd(C_SET_POST, 60'd0);
    bus_cmd(C_TSTAMP, 60'd0);
    bus_cmd(C_ARM, 60'd0);
    q_data = {}; q_delta = {};
    for (int c = 0; c <= 'h5A; c++) begin
      q_data.push_back(mk(c)); q_delta.push_back('0);
    end
    last_c = -1;
    for (int c = 0; c < 256; c++) begin
      if (done) break;
      if (c == 'h5A) trig_ts = tb_cyc;
      last_c = c;
      drive(mk(c), 4'b0100, 1'b0, 1'b0);
    end
    changed = '0;
    check("t2_done", {63'd0, done}, 64'd1);
    check("t2_last_c", 64'(last_c), 64'h5A);
    check("t2_tstamp", bus_if.bus_out, 64'(trig_ts));
    bus_cmd(C_COUNT, 60'd0);
    check("t2_count", bus_if.bus_out, 64'd91);
    bus_cmd(C_DATA, 60'd0);
    read_entries(0, 91);
    check("t2_after_rd", {62'd0, armed, done}, 64'b00);

    // ---- Test 3: long idle gap, delta saturation ----
    bus_cmd(C_SET_MASK, 60'd0);
    bus_cmd(C_ARM, 60'd0);
    q_data = {}; q_delta = {};
    q_data.push_back(mk(7)); q_delta.push_back(16'd0);
    q_data.push_back(mk(7)); q_delta.push_back(16'd65535);
    for (int c = 0; c < 70000; c++) drive(mk(7), 4'b0000, 1'b0, 1'b0);
    drive(mk(7), 4'b0000, 1'b0, 1'b1);
    stop = 1'b0;
    check("t3_flags", {62'd0, armed, done}, 64'b01);
    bus_cmd(C_STATUS, 60'd0);
    check("t3_status", bus_if.bus_out, 64'h1);
    bus_cmd(C_COUNT, 60'd0);
    check("t3_count", bus_if.bus_out, 64'd2);
    bus_cmd(C_DATA, 60'd0);
    read_entries(0, 2);

    // ---- Test 4: wrap, 310 records, post_len 10 ----
    bus_cmd(C_SET_POST, 60'd10);
    bus_cmd(C_ARM, 60'd0);
    q_data = {}; q_delta = {};
    for (int c = 0; c < 310; c++) begin
      q_data.push_back(mk(c)); q_delta.push_back('0);
      drive(mk(c), 4'b1000, c == 299, 1'b0);
    end
    changed = '0;
    check("t4_flags", {62'd0, armed, done}, 64'b01);
    bus_cmd(C_STATUS, 60'd0);
    check("t4_status", bus_if.bus_out, 64'hD);
    bus_cmd(C_COUNT, 60'd0);
    check("t4_count", bus_if.bus_out, 64'd256);
    bus_cmd(C_DATA, 60'd0);
    read_entries(54, 256);
    check("t4_after_rd", {62'd0, armed, done}, 64'b00);

    // ---- Test 5a: stop and ext_trig together ----
    bus_cmd(C_SET_POST, 60'd5);
    bus_cmd(C_STATUS, 60'd0);
    bus_cmd(C_ARM, 60'd0);
    drive(mk(1), 4'b0001, 1'b0, 1'b0);
    drive(mk(2), 4'b0001, 1'b1, 1'b1);
    check("t5a_flags", {62'd0, armed, done}, 64'b01);
    check("t5a_status", bus_if.bus_out, 64'h1);
    bus_cmd(C_COUNT, 60'd0);
    check("t5a_count", bus_if.bus_out, 64'd2);

    // ---- Test 5b: ARM during POST restarts ----
    bus_cmd(C_SET_POST, 60'd20);
    bus_cmd(C_ARM, 60'd0);
    drive(mk(0), 4'b0001, 1'b0, 1'b0);
    drive(mk(1), 4'b0001, 1'b1, 1'b0);
    drive(mk(2), 4'b0001, 1'b0, 1'b0);
    check("t5b_post_flags", {62'd0, armed, done}, 64'b10);
    check("t5b_post_count", bus_if.bus_out, 64'd3);
    changed = 4'b0001;
    bus_if.bus_in = {60'd0, C_ARM}; bus_if.bus_write = 1'b1;
    @(negedge clk);
    bus_if.bus_write = 1'b0; bus_if.bus_in = '0;
    check("t5b_rearm_count", bus_if.bus_out, 64'd0);
    check("t5b_rearm_flags", {62'd0, armed, done}, 64'b10);
    drive(mk(3), 4'b0001, 1'b0, 1'b0);
    check("t5b_rearm_count1", bus_if.bus_out, 64'd1);
    bus_cmd(C_STATUS, 60'd0);
    check("t5b_rearm_status", bus_if.bus_out, 64'h2);

    // ---- Test 5c: asynchronous reset mid-POST ----
    drive(mk(4), 4'b0001, 1'b1, 1'b0);
    changed = '0; ext_trig = 1'b0;
    check("t5c_post_status", bus_if.bus_out, 64'h6);
    #2 reset = 1'b0;
    #1;
    check("t5c_rst_flags", {62'd0, armed, done}, 64'd0);
    check("t5c_rst_bus", bus_if.bus_out, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
